contador_regressivo: RTL and testbench
======================================

CONTADOR_REGRESSIVO -- requirements
Module: contador_regressivo

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100: clk cycles per counted second; SHALL be >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 clear  input  1  synchronous clear strobe.
REQ-005 load  input  1  strobe; captures load_mins/load_sec_tens/load_sec_ones.
REQ-006 load_mins  input  4  BCD minutes, valid 0-9.
REQ-007 load_sec_tens  input  4  BCD tens of seconds, valid 0-5.
REQ-008 load_sec_ones  input  4  BCD units of seconds, valid 0-9.
REQ-009 start  input  1  strobe; begins or resumes the countdown.
REQ-010 stop  input  1  strobe; pauses the countdown.
REQ-011 mins  output  4  current BCD minutes, registered; drives the 7-segment decoder.
REQ-012 sec_tens  output  4  current BCD tens of seconds, registered.
REQ-013 sec_ones  output  4  current BCD units of seconds, registered.
REQ-014 running  output  1  high while in RUNNING.
REQ-015 done  output  1  high while in DONE.
REQ-016 load_err  output  1  one-cycle pulse on a rejected load.

Function
REQ-017 FSM states SHALL be IDLE, RUNNING, PAUSED, DONE; running = (state==RUNNING); done = (state==DONE).
REQ-018 Strobe priority per cycle SHALL be clear > stop > load > start; only the highest-priority active strobe acts.
REQ-019 clear: from any state -> IDLE; digits 0:00; prescaler 0; load_err 0.
REQ-020 load in IDLE, PAUSED or DONE with all digits valid: digits <= load values next edge; state -> IDLE; prescaler <= 0.
REQ-021 load with any invalid digit (mins>9, sec_tens>5, sec_ones>9): digits and state unchanged; load_err = 1 for exactly the next cycle.
REQ-022 load in RUNNING: ignored; no load_err.
REQ-023 start in IDLE with digits != 0:00: -> RUNNING; prescaler already 0.
REQ-024 start in PAUSED with digits != 0:00: -> RUNNING; prescaler resumes from its held value.
REQ-025 start with digits = 0:00, or in RUNNING or DONE: ignored.
REQ-026 stop in RUNNING: -> PAUSED; digits and prescaler held; stop outside RUNNING: ignored.
REQ-027 In RUNNING the prescaler SHALL count 0..TICKS_PER_SEC-1; at TICKS_PER_SEC-1 it wraps to 0 and the time decrements by one second on that edge.
REQ-028 Decrement SHALL be BCD with borrow: sec_ones 0->9 borrows from sec_tens; sec_tens 0->5 borrows from mins; mins decrements by 1.
REQ-029 First decrement after start from IDLE SHALL occur exactly TICKS_PER_SEC cycles after the start edge.
REQ-030 On the edge where the digits become 0:00, state SHALL move to DONE in the same edge; the prescaler is cleared; no further decrement (no underflow past 0:00).
REQ-031 DONE SHALL persist until clear or a valid load.
REQ-032 Digits SHALL never hold a non-BCD value or seconds > 59.
REQ-033 stop arriving on the prescaler wrap cycle SHALL win; no decrement on that edge.

Reset
REQ-034 rst_n low SHALL immediately force: state IDLE, digits 0:00, prescaler 0, running 0, done 0, load_err 0, independent of clk.
REQ-035 Reset asserted mid-countdown SHALL abort it; after release the block idles at 0:00 until load+start.

Verification (TICKS_PER_SEC=4)
REQ-036 Assert rst_n=0 asynchronously mid-RUNNING -> outputs 0/0/0, running=0, done=0 before the next clk edge.
REQ-037 load 1:00, start -> running=1; 4 cycles after start, digits 0:59; after 4 more, 0:58.
REQ-038 load 0:02, start -> 0:01 at cycle 4, 0:00 with done=1, running=0 at cycle 8; digits hold at 0:00 for 20 further cycles.
REQ-039 load 0:05, start, stop 2 cycles after start -> 0:05 held for 20 cycles; start -> 0:04 exactly 2 cycles later.
REQ-040 load 2:60 -> load_err pulse of 1 cycle; digits unchanged; load 9:5A -> same.
REQ-041 In RUNNING at 0:30, assert clear+start+load together -> next edge IDLE, 0:00, running=0, load_err=0.

Source files
------------

// File: rtl/contador_regressivo_if.sv
// Control strobes, load digits and countdown status between the timer and its controller.
// Purely structural: no latency, no backpressure.
interface contador_regressivo_if;
  logic       clear;
  logic       load;
  logic       start;
  logic       stop;
  logic [3:0] load_mins;
  logic [3:0] load_sec_tens;
  logic [3:0] load_sec_ones;
  logic [3:0] mins;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       done;
  logic       load_err;

  modport master (
    output clear, load, start, stop, load_mins, load_sec_tens, load_sec_ones,
    input  mins, sec_tens, sec_ones, running, done, load_err
  );

  modport slave (
    input  clear, load, start, stop, load_mins, load_sec_tens, load_sec_ones,
    output mins, sec_tens, sec_ones, running, done, load_err
  );
endinterface

// File: rtl/contador_regressivo.sv
// BCD M:SS countdown timer; all outputs registered, one-second step every TICKS_PER_SEC clocks.
// Strobes act on the next edge with priority clear > stop > load > start; no backpressure.
module contador_regressivo #(
  parameter int TICKS_PER_SEC = 100
) (
  input logic                  clk,
  input logic                  rst_n,
  contador_regressivo_if.slave bus
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    mins_q;
  logic [3:0]    tens_q;
  logic [3:0]    ones_q;
  logic          running_q;
  logic          done_q;
  logic          load_err_q;

  logic       load_ok;
  logic       is_zero;
  logic       last_sec;
  logic [3:0] dec_m;
  logic [3:0] dec_t;
  logic [3:0] dec_o;

  assign load_ok  = (bus.load_mins <= 4'd9) && (bus.load_sec_tens <= 4'd5) &&
                    (bus.load_sec_ones <= 4'd9);
  assign is_zero  = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  assign last_sec = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);

  // Borrow chain only ever sees non-zero time: RUNNING is never entered at 0:00.
  always_comb begin
    dec_m = mins_q;
    dec_t = tens_q;
    dec_o = ones_q - 4'd1;
    if (ones_q == 4'd0) begin
      dec_o = 4'd9;
      if (tens_q == 4'd0) begin
        dec_t = 4'd5;
        dec_m = mins_q - 4'd1;
      end else begin
        dec_t = tens_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      presc      <= '0;
      mins_q     <= 4'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= 1'b0;
      if (bus.clear) begin
        state     <= IDLE;
        presc     <= '0;
        mins_q    <= 4'd0;
        tens_q    <= 4'd0;
        ones_q    <= 4'd0;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else if (state == RUNNING) begin
        // stop beats the wrap edge; load/start are meaningless while counting
        if (bus.stop) begin
          state     <= PAUSED;
          running_q <= 1'b0;
        end else if (presc == LAST_TICK) begin
          presc  <= '0;
          mins_q <= dec_m;
          tens_q <= dec_t;
          ones_q <= dec_o;
          if (last_sec) begin
            state     <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end else if (!bus.stop) begin
        if (bus.load) begin
          if (load_ok) begin
            state  <= IDLE;
            presc  <= '0;
            mins_q <= bus.load_mins;
            tens_q <= bus.load_sec_tens;
            ones_q <= bus.load_sec_ones;
            done_q <= 1'b0;
          end else begin
            load_err_q <= 1'b1;
          end
        end else if (bus.start && !is_zero && (state != DONE)) begin
          // IDLE always holds presc at 0; PAUSED resumes mid-second
          state     <= RUNNING;
          running_q <= 1'b1;
        end
      end
    end
  end

  assign bus.mins     = mins_q;
  assign bus.sec_tens = tens_q;
  assign bus.sec_ones = ones_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_contador_regressivo.sv
// Bench for contador_regressivo at TICKS_PER_SEC=4: per-scenario expectation queues keyed by
// cycle offset, sampled 1 time unit after each rising edge.
module tb_contador_regressivo;

  logic clk;
  logic rst_n;
  contador_regressivo_if bus ();

  contador_regressivo #(.TICKS_PER_SEC(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int         c;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       r;
    logic       d;
    logic       le;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic set_load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
    bus.load          = 1'b1;
    bus.load_mins     = m;
    bus.load_sec_tens = t;
    bus.load_sec_ones = o;
  endtask

  task automatic push(input int c, input logic [3:0] m, input logic [3:0] t, input logic [3:0] o,
                      input logic r, input logic d, input logic le);
    exp_t e;
    e.c = c; e.m = m; e.t = t; e.o = o; e.r = r; e.d = d; e.le = le;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err} !== 15'd0) begin
      errors++;
      $display("FAIL reset_init got %h:%h%h run=%b done=%b err=%b want 0:00 0 0 0",
               bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_load(4'd1, 4'd0, 4'd0);
    step();
    bus.start = 1'b1;
    step();
    repeat (5) step();
    checks++;
    if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.running} !== {4'd0, 4'd5, 4'd9, 1'b1}) begin
      errors++;
      $display("FAIL reset_precount got %h:%h%h run=%b want 0:59 run=1",
               bus.mins, bus.sec_tens, bus.sec_ones, bus.running);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset got %h:%h%h run=%b done=%b err=%b want 0:00 0 0 0",
               bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();
    bus.start = 1'b1;
    step();
    checks++;
    if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done} !== 14'd0) begin
      errors++;
      $display("FAIL reset_idle got %h:%h%h run=%b done=%b want 0:00 0 0",
               bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done);
    end
  endtask

  task automatic test_count();
    exp_t e;
    set_load(4'd1, 4'd0, 4'd0);
    step();
    bus.start = 1'b1;
    step();
    push(0, 4'd1, 4'd0, 4'd0, 1, 0, 0);
    push(3, 4'd1, 4'd0, 4'd0, 1, 0, 0);
    push(4, 4'd0, 4'd5, 4'd9, 1, 0, 0);
    push(7, 4'd0, 4'd5, 4'd9, 1, 0, 0);
    push(8, 4'd0, 4'd5, 4'd8, 1, 0, 0);
    for (int c = 0; c <= 8; c++) begin
      while (sb.size() > 0 && sb[0].c == c) begin
        e = sb.pop_front();
        checks++;
        if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err} !==
            {e.m, e.t, e.o, e.r, e.d, e.le}) begin
          errors++;
          $display("FAIL count c=%0d got %h:%h%h r=%b d=%b e=%b want %h:%h%h r=%b d=%b e=%b", c,
                   bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err,
                   e.m, e.t, e.o, e.r, e.d, e.le);
        end
      end
      step();
    end
    if (sb.size() != 0) begin errors++; $display("FAIL count leftover %0d", sb.size()); sb.delete(); end
    bus.clear = 1'b1;
    step();
  endtask

  task automatic test_done();
    exp_t e;
    set_load(4'd0, 4'd0, 4'd2);
    step();
    bus.start = 1'b1;
    step();
    push(0,  4'd0, 4'd0, 4'd2, 1, 0, 0);
    push(4,  4'd0, 4'd0, 4'd1, 1, 0, 0);
    push(7,  4'd0, 4'd0, 4'd1, 1, 0, 0);
    push(8,  4'd0, 4'd0, 4'd0, 0, 1, 0);
    push(11, 4'd0, 4'd0, 4'd0, 0, 1, 0);
    push(28, 4'd0, 4'd0, 4'd0, 0, 1, 0);
    push(30, 4'd0, 4'd0, 4'd3, 0, 0, 0);
    for (int c = 0; c <= 30; c++) begin
      while (sb.size() > 0 && sb[0].c == c) begin
        e = sb.pop_front();
        checks++;
        if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err} !==
            {e.m, e.t, e.o, e.r, e.d, e.le}) begin
          errors++;
          $display("FAIL done c=%0d got %h:%h%h r=%b d=%b e=%b want %h:%h%h r=%b d=%b e=%b", c,
                   bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err,
                   e.m, e.t, e.o, e.r, e.d, e.le);
        end
      end
      if (c == 10) bus.start = 1'b1;
      if (c == 29) set_load(4'd0, 4'd0, 4'd3);
      step();
    end
    if (sb.size() != 0) begin errors++; $display("FAIL done leftover %0d", sb.size()); sb.delete(); end
    bus.clear = 1'b1;
    step();
  endtask

  task automatic test_pause();
    exp_t e;
    set_load(4'd0, 4'd0, 4'd5);
    step();
    bus.start = 1'b1;
    step();
    for (int c = 0; c <= 2; c++) push(c, 4'd0, 4'd0, 4'd5, 1, 0, 0);
    for (int c = 3; c <= 22; c++) push(c, 4'd0, 4'd0, 4'd5, 0, 0, 0);
    push(23, 4'd0, 4'd0, 4'd5, 1, 0, 0);
    push(24, 4'd0, 4'd0, 4'd5, 1, 0, 0);
    push(25, 4'd0, 4'd0, 4'd4, 1, 0, 0);
    push(28, 4'd0, 4'd0, 4'd4, 1, 0, 0);
    for (int c = 29; c <= 31; c++) push(c, 4'd0, 4'd0, 4'd4, 0, 0, 0);
    push(32, 4'd0, 4'd0, 4'd4, 1, 0, 0);
    push(33, 4'd0, 4'd0, 4'd3, 1, 0, 0);
    for (int c = 0; c <= 33; c++) begin
      while (sb.size() > 0 && sb[0].c == c) begin
        e = sb.pop_front();
        checks++;
        if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err} !==
            {e.m, e.t, e.o, e.r, e.d, e.le}) begin
          errors++;
          $display("FAIL pause c=%0d got %h:%h%h r=%b d=%b e=%b want %h:%h%h r=%b d=%b e=%b", c,
                   bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err,
                   e.m, e.t, e.o, e.r, e.d, e.le);
        end
      end
      if (c == 2 || c == 28) bus.stop = 1'b1;
      if (c == 22 || c == 31) bus.start = 1'b1;
      step();
    end
    if (sb.size() != 0) begin errors++; $display("FAIL pause leftover %0d", sb.size()); sb.delete(); end
    bus.clear = 1'b1;
    step();
  endtask

  task automatic test_load_err();
    exp_t e;
    bus.clear = 1'b1;
    step();
    push(0,  4'd0, 4'd0, 4'd0, 0, 0, 0);
    push(1,  4'd3, 4'd2, 4'd1, 0, 0, 0);
    push(2,  4'd3, 4'd2, 4'd1, 0, 0, 1);
    push(3,  4'd3, 4'd2, 4'd1, 0, 0, 0);
    push(4,  4'd3, 4'd2, 4'd1, 0, 0, 1);
    push(5,  4'd3, 4'd2, 4'd1, 0, 0, 0);
    push(6,  4'd3, 4'd2, 4'd1, 0, 0, 1);
    push(7,  4'd3, 4'd2, 4'd1, 0, 0, 0);
    push(8,  4'd3, 4'd2, 4'd1, 1, 0, 0);
    push(9,  4'd3, 4'd2, 4'd1, 1, 0, 0);
    push(10, 4'd3, 4'd2, 4'd1, 1, 0, 0);
    for (int c = 0; c <= 10; c++) begin
      while (sb.size() > 0 && sb[0].c == c) begin
        e = sb.pop_front();
        checks++;
        if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err} !==
            {e.m, e.t, e.o, e.r, e.d, e.le}) begin
          errors++;
          $display("FAIL load_err c=%0d got %h:%h%h r=%b d=%b e=%b want %h:%h%h r=%b d=%b e=%b", c,
                   bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err,
                   e.m, e.t, e.o, e.r, e.d, e.le);
        end
      end
      case (c)
        0: set_load(4'd3, 4'd2, 4'd1);
        1: set_load(4'd2, 4'd6, 4'd0);
        3: set_load(4'd9, 4'd5, 4'hA);
        5: set_load(4'hA, 4'd0, 4'd0);
        7: bus.start = 1'b1;
        8: set_load(4'd2, 4'd6, 4'd0);
        9: set_load(4'd1, 4'd1, 4'd1);
        default: ;
      endcase
      step();
    end
    if (sb.size() != 0) begin errors++; $display("FAIL load_err leftover %0d", sb.size()); sb.delete(); end
    bus.clear = 1'b1;
    step();
  endtask

  task automatic test_clear_priority();
    exp_t e;
    set_load(4'd0, 4'd3, 4'd1);
    step();
    bus.start = 1'b1;
    step();
    push(0,  4'd0, 4'd3, 4'd1, 1, 0, 0);
    push(4,  4'd0, 4'd3, 4'd0, 1, 0, 0);
    push(5,  4'd0, 4'd0, 4'd0, 0, 0, 0);
    push(8,  4'd0, 4'd0, 4'd0, 0, 0, 0);
    push(9,  4'd0, 4'd0, 4'd1, 0, 0, 0);
    push(10, 4'd0, 4'd0, 4'd1, 1, 0, 0);
    push(13, 4'd0, 4'd0, 4'd1, 1, 0, 0);
    push(14, 4'd0, 4'd0, 4'd0, 0, 1, 0);
    for (int c = 0; c <= 14; c++) begin
      while (sb.size() > 0 && sb[0].c == c) begin
        e = sb.pop_front();
        checks++;
        if ({bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err} !==
            {e.m, e.t, e.o, e.r, e.d, e.le}) begin
          errors++;
          $display("FAIL clear_prio c=%0d got %h:%h%h r=%b d=%b e=%b want %h:%h%h r=%b d=%b e=%b", c,
                   bus.mins, bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.load_err,
                   e.m, e.t, e.o, e.r, e.d, e.le);
        end
      end
      if (c == 4) begin
        bus.clear = 1'b1;
        bus.start = 1'b1;
        set_load(4'd2, 4'd6, 4'd0);
      end
      if (c == 8) set_load(4'd0, 4'd0, 4'd1);
      if (c == 9) bus.start = 1'b1;
      step();
    end
    if (sb.size() != 0) begin errors++; $display("FAIL clear_prio leftover %0d", sb.size()); sb.delete(); end
    bus.clear = 1'b1;
    step();
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.clear         = 1'b0;
    bus.load          = 1'b0;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.load_mins     = 4'd0;
    bus.load_sec_tens = 4'd0;
    bus.load_sec_ones = 4'd0;
    test_reset();
    test_count();
    test_done();
    test_pause();
    test_load_err();
    test_clear_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
